dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the pipeline MEM stage (responder side of the dcache_* request interface) and the next-level memory (initiator side of a req/ack word interface).
- Read and write hits complete with zero stall.
- Misses raise dcache_stall while an FSM performs an optional dirty writeback, then a refill.

Parameters:
- INDEX_BITS, 6: set index width; 2^INDEX_BITS one-word lines.
- TAG_BITS, 24: tag width; word address = {tag, index}.
- WORD_BYTES, 4: bytes per word/line; data width = 8*WORD_BYTES.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- dcache_ren  in  1  pipeline read request.
- dcache_wen  in  1  pipeline write request.
- dcache_addr  in  TAG_BITS+INDEX_BITS  word address {tag, index}.
- byteSelectVector  in  WORD_BYTES  byte enables for writes.
- dcache_input  in  8*WORD_BYTES  write data, byte-lane aligned.
- dcache_output  out  8*WORD_BYTES  read data.
- dcache_stall  out  1  pipeline must hold its request and freeze.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write (writeback), 0 = read (refill).
- mem_addr  out  TAG_BITS+INDEX_BITS  memory word address.
- mem_wdata  out  8*WORD_BYTES  writeback data.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  8*WORD_BYTES  refill data, valid with mem_ack.

Behaviour:
- Single clock domain on clock. Reset is synchronous and active-high on reset.
- Reset effects: all valid and dirty bits cleared; state = IDLE. Outputs: dcache_stall=0, dcache_output=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-transaction aborts the transaction; any later mem_ack is ignored.
- Tag/data arrays need not be reset.
- Request: req = ren | wen. If both are asserted, the request is treated as a write and the read is ignored.
- hit = state==IDLE & valid[index] & tag[index]==addr tag.
- Read hit: dcache_output = data[index] combinationally, same cycle, stall=0. At all other times dcache_output=0.
- Write hit: at the clock edge, bytes with byteSelectVector[i]=1 are replaced from dcache_input lane i; dirty[index]=1; stall=0.
- Miss (req & ~hit in IDLE): dcache_stall=1 combinationally in the same cycle.
  - Next state is WRITEBACK if valid & dirty, else REFILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={tag[index], index}, mem_wdata=data[index].
  - On mem_ack, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr=request address.
  - On mem_ack: data=mem_rdata, tag written, valid=1, dirty=0; go to IDLE.
- Memory-side outputs are combinational from state. Back-to-back transactions are allowed; each mem_ack completes exactly one transaction.
- dcache_stall=1 in every cycle where state≠IDLE, including ack cycles.
- On return to IDLE the held request hits. A write then merges on that edge (write-allocate).
- Timing: with memory latency L (mem_ack in the L-th cycle of mem_req high, L≥1):
  - clean miss stalls L+1 cycles;
  - dirty miss stalls 2L+1 cycles.
- The pipeline holds ren/wen/addr/data stable while stall=1. If the request drops mid-miss, the FSM still completes the transaction and installs the line.
- mem_ack outside WRITEBACK/REFILL is ignored.
- Index wrap: addresses that differ only in tag map to the same line and evict each other.

Optional Feature:
- Macro: DCACHE_FULL_WORD_WRITE_EN.
- Defined:
  - A write miss with byteSelectVector all-ones skips REFILL.
  - After the writeback if the victim is dirty, or directly from IDLE on the miss edge if it is clean, the line is installed from dcache_input with valid=1, dirty=1.
  - Stall lasts 1 cycle for a clean victim, L+1 for a dirty victim.
- Undefined: all write misses refill first.

Test Plan:
- After reset, ren addr 0x00000010 → stall=1 same cycle; REFILL mem_addr=0x00000010, mem_we=0. With L=2 and mem_rdata=0xDEADBEEF, stall lasts 3 cycles, then dcache_output=0xDEADBEEF with stall=0.
- wen addr 0x00000010, byteSelectVector=0b0011, dcache_input=0x12345678 to the hit line → no stall; next read returns 0xDEAD5678.
- Read addr 0x00000050 (index 0x10, tag 1) while line 0x10 is dirty → WRITEBACK mem_addr=0x00000010, mem_wdata=0xDEAD5678. Then REFILL mem_addr=0x00000050. With L=1, stall lasts 3 cycles.
- ren and wen both asserted, addr hit, byteSelectVector=0b1111, dcache_input=0xA5A5A5A5 → treated as write; next read returns 0xA5A5A5A5, line dirty.
- Assert reset in the second REFILL cycle, then pulse mem_ack → all outputs 0, state IDLE, no install. A read of the same address misses again.
- With DCACHE_FULL_WORD_WRITE_EN, wen addr 0x00000001 (clean victim), byteSelectVector=0b1111, data 0xCAFEF00D → stall exactly 1 cycle, mem_req never asserted, read returns 0xCAFEF00D.

Source files
------------

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate L1 data cache
// Optional DCACHE_FULL_WORD_WRITE_EN: full-word write misses install without a refill.
module dcache_controller #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 24,
   parameter int WORD_BYTES = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           dcache_ren,
   input  logic                           dcache_wen,
   input  logic [TAG_BITS+INDEX_BITS-1:0] dcache_addr,
   input  logic [WORD_BYTES-1:0]          byteSelectVector,
   input  logic [8*WORD_BYTES-1:0]        dcache_input,
   output logic [8*WORD_BYTES-1:0]        dcache_output,
   output logic                           dcache_stall,
   output logic                           mem_req,
   output logic                           mem_we,
   output logic [TAG_BITS+INDEX_BITS-1:0] mem_addr,
   output logic [8*WORD_BYTES-1:0]        mem_wdata,
   input  logic                           mem_ack,
   input  logic [8*WORD_BYTES-1:0]        mem_rdata
);
   localparam int AW    = TAG_BITS + INDEX_BITS;
   localparam int DW    = 8 * WORD_BYTES;
   localparam int LINES = 1 << INDEX_BITS;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WRITEBACK = 2'd1;
   localparam logic [1:0] S_REFILL    = 2'd2;

   logic [1:0]          r_state;
   logic [LINES-1:0]    r_valid;
   logic [LINES-1:0]    r_dirty;
   logic [TAG_BITS-1:0] r_tag  [LINES];
   logic [DW-1:0]       r_data [LINES];
   logic [AW-1:0]       r_miss_addr;

   logic                  w_req;
   logic [INDEX_BITS-1:0] w_index;
   logic [TAG_BITS-1:0]   w_tag;
   logic [INDEX_BITS-1:0] w_miss_index;
   logic                  w_idle;
   logic                  w_hit;
   logic                  w_miss;
   logic                  w_victim_dirty;
   logic                  w_full_write;
   logic                  w_miss_fw;
   logic [DW-1:0]         w_fw_data;
   logic                  w_fw_now;
   logic                  w_fw_after_wb;
   logic                  w_fill;

   assign w_req          = dcache_ren | dcache_wen;
   assign w_index        = dcache_addr[INDEX_BITS-1:0];
   assign w_tag          = dcache_addr[AW-1:INDEX_BITS];
   assign w_miss_index   = r_miss_addr[INDEX_BITS-1:0];
   assign w_idle         = (r_state == S_IDLE);
   assign w_hit          = w_idle & r_valid[w_index] & (r_tag[w_index] == w_tag);
   assign w_miss         = w_idle & w_req & ~w_hit;
   assign w_victim_dirty = r_valid[w_index] & r_dirty[w_index];

`ifdef DCACHE_FULL_WORD_WRITE_EN
   logic          r_miss_fw;
   logic [DW-1:0] r_miss_data;

   always_ff @(posedge clock) begin
      if (w_miss) begin
         r_miss_fw   <= w_full_write;
         r_miss_data <= dcache_input;
      end
   end

   assign w_full_write = dcache_wen & (&byteSelectVector);
   assign w_miss_fw    = r_miss_fw;
   assign w_fw_data    = r_miss_data;
`else
   assign w_full_write = 1'b0;
   assign w_miss_fw    = 1'b0;
   assign w_fw_data    = '0;
`endif

   assign w_fw_now      = w_miss & ~w_victim_dirty & w_full_write;
   assign w_fw_after_wb = (r_state == S_WRITEBACK) & mem_ack & w_miss_fw;
   assign w_fill        = (r_state == S_REFILL) & mem_ack;

   // Latch the miss address so the transaction completes even if the request drops.
   always_ff @(posedge clock) begin
      if (w_miss) r_miss_addr <= dcache_addr;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hit && dcache_wen) begin
                  r_dirty[w_index] <= 1'b1;
               end else if (w_miss) begin
                  if (w_victim_dirty) begin
                     r_state <= S_WRITEBACK;
                  end else if (w_full_write) begin
                     r_valid[w_index] <= 1'b1;
                     r_dirty[w_index] <= 1'b1;
                  end else begin
                     r_state <= S_REFILL;
                  end
               end
            end
            S_WRITEBACK: begin
               if (mem_ack) begin
                  if (w_miss_fw) begin
                     r_valid[w_miss_index] <= 1'b1;
                     r_dirty[w_miss_index] <= 1'b1;
                     r_state               <= S_IDLE;
                  end else begin
                     r_state <= S_REFILL;
                  end
               end
            end
            S_REFILL: begin
               if (mem_ack) begin
                  r_valid[w_miss_index] <= 1'b1;
                  r_dirty[w_miss_index] <= 1'b0;
                  r_state               <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         if (w_hit && dcache_wen) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
               if (byteSelectVector[b]) r_data[w_index][b*8 +: 8] <= dcache_input[b*8 +: 8];
            end
         end else if (w_fw_now) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= dcache_input;
         end else if (w_fw_after_wb) begin
            r_tag[w_miss_index]  <= r_miss_addr[AW-1:INDEX_BITS];
            r_data[w_miss_index] <= w_fw_data;
         end else if (w_fill) begin
            r_tag[w_miss_index]  <= r_miss_addr[AW-1:INDEX_BITS];
            r_data[w_miss_index] <= mem_rdata;
         end
      end
   end

   assign dcache_output = (w_hit && dcache_ren && !dcache_wen) ? r_data[w_index] : '0;
   assign dcache_stall  = ~w_idle | w_miss;

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         S_WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {r_tag[w_miss_index], w_miss_index};
            mem_wdata = r_data[w_miss_index];
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = r_miss_addr;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - randomized bench for dcache_controller against a line-level model
// Honours DCACHE_FULL_WORD_WRITE_EN when defined for the build.
module tb_dcache_controller;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        dcache_ren = 1'b0;
   logic        dcache_wen = 1'b0;
   logic [29:0] dcache_addr = '0;
   logic [3:0]  byteSelectVector = '0;
   logic [31:0] dcache_input = '0;
   logic [31:0] dcache_output;
   logic        dcache_stall;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   dcache_controller dut (
      .clock(clock), .reset(reset),
      .dcache_ren(dcache_ren), .dcache_wen(dcache_wen), .dcache_addr(dcache_addr),
      .byteSelectVector(byteSelectVector), .dcache_input(dcache_input),
      .dcache_output(dcache_output), .dcache_stall(dcache_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Next-level memory: sparse backing store with an address-derived default pattern.
   logic [31:0] mem [logic [29:0]];

   function automatic logic [31:0] mem_rd(input logic [29:0] a);
      if (mem.exists(a)) return mem[a];
      return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A_C3C3;
   endfunction

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t seen[$];
   int   lat = 1;
   bit   resp_en = 1'b1;
   int   rcnt = 0;

   always @(negedge clock) begin
      if (resp_en) begin
         mem_ack = 1'b0;
         if (mem_req) begin
            rcnt++;
            if (rcnt >= lat) begin
               mem_ack = 1'b1;
               rcnt    = 0;
               seen.push_back('{mem_we, mem_addr, mem_wdata});
               if (mem_we) mem[mem_addr] = mem_wdata;
               else        mem_rdata = mem_rd(mem_addr);
            end
         end else begin
            rcnt = 0;
         end
      end else begin
         rcnt = 0;
      end
   end

   // Reference model: one entry per line, updated once per completed access.
   bit          mv   [64];
   bit          md   [64];
   logic [23:0] mt   [64];
   logic [31:0] mdat [64];

   task automatic access(input bit ren, input bit wen, input logic [29:0] addr,
                         input logic [3:0] bsv, input logic [31:0] din, output logic [31:0] out);
      int          idx;
      logic [23:0] tg;
      bit          hit, full, vd;
      int          exp_stall, n;
      logic [31:0] expo;
      txn_t        exp[$];
      idx  = int'(addr[5:0]);
      tg   = addr[29:6];
      hit  = mv[idx] && (mt[idx] == tg);
      full = 1'b0;
`ifdef DCACHE_FULL_WORD_WRITE_EN
      full = wen && (bsv == 4'hF);
`endif
      exp_stall = 0;
      if (!hit) begin
         vd = mv[idx] && md[idx];
         if (vd) exp.push_back('{1'b1, {mt[idx], addr[5:0]}, mdat[idx]});
         if (!full) exp.push_back('{1'b0, addr, 32'h0});
         if (full) exp_stall = vd ? lat + 1 : 1;
         else      exp_stall = vd ? 2 * lat + 1 : lat + 1;
         mdat[idx] = full ? din : mem_rd(addr);
         mv[idx]   = 1'b1;
         mt[idx]   = tg;
         md[idx]   = full;
      end
      if (wen) begin
         for (int b = 0; b < 4; b++) if (bsv[b]) mdat[idx][b*8 +: 8] = din[b*8 +: 8];
         md[idx] = 1'b1;
         expo    = 32'h0;
      end else begin
         expo = mdat[idx];
      end

      seen.delete();
      dcache_ren       = ren;
      dcache_wen       = wen;
      dcache_addr      = addr;
      byteSelectVector = bsv;
      dcache_input     = din;
      n = 0;
      @(negedge clock);
      while (dcache_stall && n < 40) begin
         n++;
         @(negedge clock);
      end
      check("stall_cycles", 32'(n), 32'(exp_stall));
      check("out_data", dcache_output, expo);
      check("mem_req_idle", 32'(mem_req), 32'h0);
      out = dcache_output;
      @(posedge clock);
      #1;
      dcache_ren = 1'b0;
      dcache_wen = 1'b0;
      check("txn_count", 32'(seen.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
         check("txn_we", 32'(seen[i].we), 32'(exp[i].we));
         check("txn_addr", 32'(seen[i].addr), 32'(exp[i].addr));
         if (exp[i].we) check("txn_wdata", seen[i].wdata, exp[i].wdata);
      end
   endtask

   logic [31:0] o;

   initial begin
      repeat (3) @(negedge clock);
      check("rst_stall", 32'(dcache_stall), 32'h0);
      check("rst_out", dcache_output, 32'h0);
      check("rst_req", 32'(mem_req), 32'h0);
      check("rst_we", 32'(mem_we), 32'h0);
      check("rst_addr", 32'(mem_addr), 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      @(posedge clock);
      #1 reset = 1'b0;

      lat = 2;
      mem[30'h10] = 32'hDEADBEEF;
      access(1'b1, 1'b0, 30'h10, 4'h0, 32'h0, o);
      check("tp_refill_data", o, 32'hDEADBEEF);
      access(1'b0, 1'b1, 30'h10, 4'b0011, 32'h12345678, o);
      access(1'b1, 1'b0, 30'h10, 4'h0, 32'h0, o);
      check("tp_merge_data", o, 32'hDEAD5678);
      lat = 1;
      access(1'b1, 1'b0, 30'h50, 4'h0, 32'h0, o);
      check("tp_wb_mem", mem_rd(30'h10), 32'hDEAD5678);
      access(1'b1, 1'b1, 30'h50, 4'hF, 32'hA5A5A5A5, o);
      access(1'b1, 1'b0, 30'h50, 4'h0, 32'h0, o);
      check("tp_both_data", o, 32'hA5A5A5A5);

      // Reset in the second REFILL cycle, then a stray ack that must not install.
      resp_en = 1'b0;
      mem_ack = 1'b0;
      dcache_ren  = 1'b1;
      dcache_addr = 30'h3F;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("abort_req", 32'(mem_req), 32'h1);
      check("abort_addr", 32'(mem_addr), 32'h3F);
      reset = 1'b1;
      @(posedge clock); #1;
      reset      = 1'b0;
      dcache_ren = 1'b0;
      mem_ack    = 1'b1;
      mem_rdata  = 32'h0BAD0BAD;
      @(posedge clock); #1;
      mem_ack = 1'b0;
      @(negedge clock);
      check("abort_stall", 32'(dcache_stall), 32'h0);
      check("abort_mreq", 32'(mem_req), 32'h0);
      check("abort_maddr", 32'(mem_addr), 32'h0);
      check("abort_out", dcache_output, 32'h0);
      for (int i = 0; i < 64; i++) begin
         mv[i] = 1'b0;
         md[i] = 1'b0;
      end
      @(posedge clock); #1;
      resp_en = 1'b1;
      lat = 2;
      access(1'b1, 1'b0, 30'h3F, 4'h0, 32'h0, o);
      check("abort_remiss", o, mem_rd(30'h3F));

`ifdef DCACHE_FULL_WORD_WRITE_EN
      access(1'b0, 1'b1, 30'h01, 4'hF, 32'hCAFEF00D, o);
      access(1'b1, 1'b0, 30'h01, 4'h0, 32'h0, o);
      check("fw_data", o, 32'hCAFEF00D);
`endif

      for (int k = 0; k < 300; k++) begin
         bit          r, w;
         logic [29:0] a;
         int          sel;
         sel = int'($urandom_range(0, 2));
         r   = (sel != 1);
         w   = (sel != 0);
         a   = {22'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
         lat = int'($urandom_range(1, 3));
         access(r, w, a, 4'($urandom), $urandom, o);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
